// File: rtl/ucsbece154b_perf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ucsbece154b_perf_pkg
// Purpose  : Shared types and constants for the performance monitor:
//            monitor state encoding, readout select codes, the canonical
//            RISC-V NOP encoding and the default RUN-cycle limit.
// Revision : 1.0 - initial release
// ============================================================================
package ucsbece154b_perf_pkg;

  // State encoding is visible on the readout port (select 6).
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  // Readout select codes.
  localparam logic [2:0] SEL_CYCLES    = 3'd0;
  localparam logic [2:0] SEL_INSTR     = 3'd1;
  localparam logic [2:0] SEL_BRANCH    = 3'd2;
  localparam logic [2:0] SEL_BR_MISS   = 3'd3;
  localparam logic [2:0] SEL_JUMP      = 3'd4;
  localparam logic [2:0] SEL_JUMP_MISS = 3'd5;
  localparam logic [2:0] SEL_STATE     = 3'd6;
  localparam logic [2:0] SEL_ZERO      = 3'd7;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int DEFAULT_MAX_CYCLES = 500;

  // Counter bank layout.
  localparam int NUM_CNT       = 6;
  localparam int CNT_CYCLES    = 0;
  localparam int CNT_INSTR     = 1;
  localparam int CNT_BRANCH    = 2;
  localparam int CNT_BR_MISS   = 3;
  localparam int CNT_JUMP      = 4;
  localparam int CNT_JUMP_MISS = 5;

  function automatic logic is_nop(input logic [31:0] instr);
    return instr == NOP_INSTR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ucsbece154b_perf_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : ucsbece154b_sat_counter
// Purpose  : W-bit event counter that adds 0..2 per cycle and sticks at
//            all-ones instead of wrapping.
// Ports    : clk   - clock, rising edge
//            reset - synchronous active-low reset (0 = reset)
//            clr   - synchronous clear to zero
//            inc   - increment amount for this cycle (0..2)
//            q     - current count
// Revision : 1.0 - initial release
// ============================================================================
module ucsbece154b_sat_counter
  import ucsbece154b_perf_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [1:0]   inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  // Two guard bits so any 2-bit increment on top of all-ones is detected.
  logic [W+1:0] sum;

  always_comb begin
    sum = {2'b00, q_q} + (W+2)'(inc);
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (|sum[W+1:W]) begin
      q_d = '1;
    end else begin
      q_d = sum[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/ucsbece154b_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module   : ucsbece154b_perf_monitor
// Purpose  : Dual-issue pipeline performance monitor. Counts cycles, issued
//            instructions, branches, branch mispredicts, jumps and jump
//            mispredicts while RUNning, detects the halt idiom (both fetch
//            slots stuck on the same PCs executing NOPs) and stops at a
//            RUN-cycle limit.
// Ports    : clk, reset (sync, active-low)
//            en_i            - start monitoring from IDLE
//            clear_i         - return to IDLE and zero everything
//            issue1_i/2_i    - slot 1/2 issued a real instruction
//            branchE_i, mispredictE_i, jumpE_i, jumpTakenF_i - control flow
//            pcF1_i/pcF2_i, instrF1_i/instrF2_i - fetch stage per slot
//            sel_i           - readout select
//            data_o          - registered readout (one cycle after sel_i)
//            halted_o/timeout_o - state flags
// Revision : 1.0 - initial release
// ============================================================================
module ucsbece154b_perf_monitor
  import ucsbece154b_perf_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = DEFAULT_MAX_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic        clear_i,
  input  logic        issue1_i,
  input  logic        issue2_i,
  input  logic        branchE_i,
  input  logic        mispredictE_i,
  input  logic        jumpE_i,
  input  logic        jumpTakenF_i,
  input  logic [31:0] pcF1_i,
  input  logic [31:0] pcF2_i,
  input  logic [31:0] instrF1_i,
  input  logic [31:0] instrF2_i,
  input  logic [2:0]  sel_i,
  output logic [31:0] data_o,
  output logic        halted_o,
  output logic        timeout_o
);

  // Limit comparison is done at least 32 bits wide so a narrow counter is
  // never matched against a truncated copy of MAX_CYCLES-1.
  localparam int CMP_W = (CNT_W > 32) ? CNT_W : 32;

  state_e      state_q;
  state_e      state_d;
  logic [31:0] prev1_q;
  logic [31:0] prev1_d;
  logic [31:0] prev2_q;
  logic [31:0] prev2_d;
  logic        prev_valid_q;
  logic        prev_valid_d;
  logic [31:0] data_q;
  logic [31:0] data_d;

  logic [CNT_W-1:0] cnt_q  [NUM_CNT];
  logic [1:0]       inc    [NUM_CNT];
  logic [31:0]      cnt32  [NUM_CNT];

  logic             halt_cond;
  logic             count_en;
  logic             at_limit;
  logic [CMP_W-1:0] cycles_ext;

  // --------------------------------------------------------------------------
  // Halt idiom: both slots re-fetch the PCs seen last RUN cycle and both are
  // NOPs. prev_valid keeps a stale pair from a previous run from matching.
  // --------------------------------------------------------------------------
  assign halt_cond = prev_valid_q
                   && (pcF1_i == prev1_q)
                   && (pcF2_i == prev2_q)
                   && is_nop(instrF1_i)
                   && is_nop(instrF2_i);

  // The halt-detection cycle itself is not counted.
  assign count_en = (state_q == ST_RUN) && !halt_cond && !clear_i;

  assign cycles_ext = CMP_W'(cnt_q[CNT_CYCLES]);
  assign at_limit   = (cycles_ext == CMP_W'(MAX_CYCLES - 1));

  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      inc[i] = 2'd0;
    end
    if (count_en) begin
      inc[CNT_CYCLES]    = 2'd1;
      inc[CNT_INSTR]     = {1'b0, issue1_i} + {1'b0, issue2_i};
      inc[CNT_BRANCH]    = {1'b0, branchE_i};
      inc[CNT_BR_MISS]   = {1'b0, branchE_i & mispredictE_i};
      inc[CNT_JUMP]      = {1'b0, jumpE_i};
      inc[CNT_JUMP_MISS] = {1'b0, jumpE_i & ~jumpTakenF_i};
    end
  end

  // --------------------------------------------------------------------------
  // Counter bank
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    ucsbece154b_sat_counter #(
      .W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clear_i),
      .inc   (inc[gi]),
      .q     (cnt_q[gi])
    );

    if (CNT_W >= 32) begin : g_trunc
      assign cnt32[gi] = cnt_q[gi][31:0];
    end else begin : g_zext
      assign cnt32[gi] = {{(32 - CNT_W){1'b0}}, cnt_q[gi]};
    end
  end

  // --------------------------------------------------------------------------
  // State / previous-PC next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    prev1_d      = prev1_q;
    prev2_d      = prev2_q;
    prev_valid_d = prev_valid_q;

    if (clear_i) begin
      state_d      = ST_IDLE;
      prev1_d      = '0;
      prev2_d      = '0;
      prev_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en_i) begin
            state_d      = ST_RUN;
            prev_valid_d = 1'b0;
          end
        end
        ST_RUN: begin
          prev1_d      = pcF1_i;
          prev2_d      = pcF2_i;
          prev_valid_d = 1'b1;
          // Halt wins over timeout in the same cycle.
          if (halt_cond) begin
            state_d = ST_HALTED;
          end else if (at_limit) begin
            state_d = ST_TIMEOUT;
          end
        end
        ST_HALTED:  state_d = ST_HALTED;
        ST_TIMEOUT: state_d = ST_TIMEOUT;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Readout mux
  // --------------------------------------------------------------------------
  always_comb begin
    data_d = '0;
    case (sel_i)
      SEL_CYCLES:    data_d = cnt32[CNT_CYCLES];
      SEL_INSTR:     data_d = cnt32[CNT_INSTR];
      SEL_BRANCH:    data_d = cnt32[CNT_BRANCH];
      SEL_BR_MISS:   data_d = cnt32[CNT_BR_MISS];
      SEL_JUMP:      data_d = cnt32[CNT_JUMP];
      SEL_JUMP_MISS: data_d = cnt32[CNT_JUMP_MISS];
      SEL_STATE:     data_d = {30'b0, state_q};
      SEL_ZERO:      data_d = '0;
      default:       data_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      prev1_q      <= '0;
      prev2_q      <= '0;
      prev_valid_q <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      prev1_q      <= prev1_d;
      prev2_q      <= prev2_d;
      prev_valid_q <= prev_valid_d;
      data_q       <= data_d;
    end
  end

  assign data_o    = data_q;
  assign halted_o  = (state_q == ST_HALTED);
  assign timeout_o = (state_q == ST_TIMEOUT);

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154b_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_ucsbece154b_perf_monitor
// Purpose  : Scoreboard bench for the performance monitor. Three instances
//            share stimulus: u0 (CNT_W=32, MAX_CYCLES=500), u1 (MAX_CYCLES=8)
//            and u2 (CNT_W=4). Expected values are queued with the cycle in
//            which the DUT must present them; a monitor compares on negedge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ucsbece154b_perf_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_i, clear_i, issue1_i, issue2_i;
    logic        branchE_i, mispredictE_i, jumpE_i, jumpTakenF_i;
    logic [31:0] pcF1_i, pcF2_i, instrF1_i, instrF2_i;
    logic [2:0]  sel_i;
    logic [31:0] d0, d1, d2;
    logic        h0, h1, h2, t0, t1, t2;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int w_wait = 0;

    int          q_due  [$];
    int          q_dut  [$];
    int          q_kind [$];
    logic [31:0] q_exp  [$];
    string       q_name [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ucsbece154b_perf_monitor #(.CNT_W(32), .MAX_CYCLES(500)) u0 (
        .clk(clk), .reset(reset), .en_i(en_i), .clear_i(clear_i),
        .issue1_i(issue1_i), .issue2_i(issue2_i), .branchE_i(branchE_i),
        .mispredictE_i(mispredictE_i), .jumpE_i(jumpE_i), .jumpTakenF_i(jumpTakenF_i),
        .pcF1_i(pcF1_i), .pcF2_i(pcF2_i), .instrF1_i(instrF1_i), .instrF2_i(instrF2_i),
        .sel_i(sel_i), .data_o(d0), .halted_o(h0), .timeout_o(t0));

    ucsbece154b_perf_monitor #(.CNT_W(32), .MAX_CYCLES(8)) u1 (
        .clk(clk), .reset(reset), .en_i(en_i), .clear_i(clear_i),
        .issue1_i(issue1_i), .issue2_i(issue2_i), .branchE_i(branchE_i),
        .mispredictE_i(mispredictE_i), .jumpE_i(jumpE_i), .jumpTakenF_i(jumpTakenF_i),
        .pcF1_i(pcF1_i), .pcF2_i(pcF2_i), .instrF1_i(instrF1_i), .instrF2_i(instrF2_i),
        .sel_i(sel_i), .data_o(d1), .halted_o(h1), .timeout_o(t1));

    ucsbece154b_perf_monitor #(.CNT_W(4), .MAX_CYCLES(500)) u2 (
        .clk(clk), .reset(reset), .en_i(en_i), .clear_i(clear_i),
        .issue1_i(issue1_i), .issue2_i(issue2_i), .branchE_i(branchE_i),
        .mispredictE_i(mispredictE_i), .jumpE_i(jumpE_i), .jumpTakenF_i(jumpTakenF_i),
        .pcF1_i(pcF1_i), .pcF2_i(pcF2_i), .instrF1_i(instrF1_i), .instrF2_i(instrF2_i),
        .sel_i(sel_i), .data_o(d2), .halted_o(h2), .timeout_o(t2));

    always @(negedge clk) begin : mon
        int          d;
        int          k;
        logic [31:0] e;
        logic [31:0] got;
        string       nm;
        while (q_due.size() > 0 && q_due[0] <= cyc) begin
            void'(q_due.pop_front());
            d  = q_dut.pop_front();
            k  = q_kind.pop_front();
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            case (d)
                0:       got = (k == 0) ? d0 : {30'b0, h0, t0};
                1:       got = (k == 0) ? d1 : {30'b0, h1, t1};
                default: got = (k == 0) ? d2 : {30'b0, h2, t2};
            endcase
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_now(input string nm, input logic [31:0] got, input logic [31:0] e);
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, e);
        end
    endtask

    task automatic push(input int d, input int k, input logic [31:0] e, input string nm);
        q_due.push_back(cyc + 1);
        q_dut.push_back(d);
        q_kind.push_back(k);
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic exp_data(input int d, input logic [2:0] s, input logic [31:0] e, input string nm);
        sel_i = s;
        push(d, 0, e, nm);
    endtask

    task automatic exp_stat(input int d, input logic [1:0] e, input string nm);
        push(d, 1, {30'b0, e}, nm);
    endtask

    task automatic quiet();
        en_i = 0; clear_i = 0; issue1_i = 0; issue2_i = 0;
        branchE_i = 0; mispredictE_i = 0; jumpE_i = 0; jumpTakenF_i = 0;
        instrF1_i = 32'h0; instrF2_i = 32'h0;
    endtask

    task automatic set_pc(input logic [31:0] base);
        pcF1_i = base;
        pcF2_i = base + 32'd4;
    endtask

    initial begin
        quiet();
        set_pc(32'h0);
        sel_i = 3'd0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_data(i, 3'd0, 32'd0, "reset_data");
            exp_stat(i, 2'b00, "reset_status");
        end
        step();
        chk_now("reset_flags_now", {26'b0, h0, t0, h1, t1, h2, t2}, 32'd0);

        reset = 1'b1;
        en_i  = 1'b1;
        step();
        en_i = 0; issue1_i = 1; issue2_i = 1;
        for (int i = 0; i < 10; i++) begin
            set_pc(32'h100 + 32'(i * 8));
            step();
        end
        issue1_i = 0; issue2_i = 0;
        exp_data(0, 3'd0, 32'd10, "cycles_10");   step();
        exp_data(0, 3'd1, 32'd20, "instr_20");    step();
        exp_data(0, 3'd6, 32'd1,  "state_run");   step();

        mispredictE_i = 1; step();
        branchE_i = 1; step();
        mispredictE_i = 0;
        for (int i = 0; i < 3; i++) step();
        branchE_i = 0;
        jumpE_i = 1; jumpTakenF_i = 1; step(); step();
        jumpTakenF_i = 0; step();
        jumpE_i = 0;
        exp_data(0, 3'd2, 32'd4, "branches_4");  step();
        exp_data(0, 3'd3, 32'd1, "br_miss_1");   step();
        exp_data(0, 3'd4, 32'd3, "jumps_3");     step();
        exp_data(0, 3'd5, 32'd1, "jump_miss_1"); step();

        clear_i = 1; step();
        clear_i = 0;
        exp_data(0, 3'd6, 32'd0, "state_idle_clr"); step();
        exp_data(0, 3'd0, 32'd0, "cycles_clr");     step();
        en_i = 1; step();
        en_i = 0;
        set_pc(32'h0); instrF1_i = 32'h13; instrF2_i = 32'h13;
        step();
        instrF1_i = 32'h0; instrF2_i = 32'h0;
        for (int i = 0; i < 4; i++) begin
            set_pc(32'h200 + 32'(i * 8));
            step();
        end
        set_pc(32'h40); instrF1_i = 32'h13; instrF2_i = 32'h13;
        exp_stat(0, 2'b00, "pre_halt");  step();
        exp_stat(0, 2'b10, "halted");    step();
        instrF1_i = 32'h0; instrF2_i = 32'h0;
        exp_data(0, 3'd0, 32'd6, "halt_cycles_6"); step();
        exp_data(0, 3'd6, 32'd2, "state_halted");  step();
        en_i = 1;
        exp_stat(0, 2'b10, "halt_hold"); step();

        clear_i = 1; en_i = 1;
        exp_stat(0, 2'b00, "clr_pri_status"); step();
        clear_i = 0; en_i = 0;
        for (int s = 0; s < 8; s++) begin
            exp_data(0, 3'(s), 32'd0, $sformatf("clr_sel%0d", s));
            step();
        end

        en_i = 1; step();
        en_i = 0; issue1_i = 1;
        step(); step(); step();
        reset = 1'b0;
        exp_data(0, 3'd0, 32'd0, "rst_run_data");
        exp_stat(0, 2'b00, "rst_run_status");
        step();
        reset = 1'b1;
        step(); step();
        issue1_i = 0;
        exp_data(0, 3'd0, 32'd0, "rst_no_restart_cyc");   step();
        exp_data(0, 3'd1, 32'd0, "rst_no_restart_instr"); step();

        en_i = 1; step();
        en_i = 0;
        for (int i = 1; i <= 8; i++) begin
            set_pc(32'h1000 + 32'(i * 8));
            if (i == 7) exp_stat(1, 2'b00, "pre_timeout");
            if (i == 8) exp_stat(1, 2'b01, "timeout");
            step();
        end
        w_wait = 0;
        while (t1 !== 1'b1 && w_wait < 4) begin
            step();
            w_wait++;
        end
        n_checks++;
        if (t1 !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_wait: timeout_o not seen within %0d cycles", w_wait);
        end
        exp_data(1, 3'd0, 32'd8, "timeout_cycles_8"); step();
        exp_data(1, 3'd6, 32'd3, "state_timeout");    step();
        exp_stat(1, 2'b01, "timeout_hold");           step();

        clear_i = 1; step();
        clear_i = 0; en_i = 1; step();
        en_i = 0;
        for (int i = 1; i <= 6; i++) begin
            set_pc(32'h2000 + 32'(i * 8));
            step();
        end
        set_pc(32'h40); instrF1_i = 32'h13; instrF2_i = 32'h13;
        exp_stat(1, 2'b00, "pre_halt_to"); step();
        exp_stat(1, 2'b10, "halt_over_to"); step();
        instrF1_i = 32'h0; instrF2_i = 32'h0;
        exp_data(1, 3'd0, 32'd7, "halt_to_cycles_7"); step();
        exp_data(1, 3'd6, 32'd2, "halt_to_state");    step();

        clear_i = 1; step();
        clear_i = 0; en_i = 1; step();
        en_i = 0; issue1_i = 1;
        for (int i = 0; i < 14; i++) begin
            set_pc(32'h3000 + 32'(i * 8));
            step();
        end
        issue2_i = 1;
        set_pc(32'h4000);
        exp_data(2, 3'd0, 32'd14, "sat_cycles_14"); step();
        issue1_i = 0; issue2_i = 0;
        set_pc(32'h4100);
        exp_data(2, 3'd1, 32'd15, "sat_instr_15");  step();
        set_pc(32'h4200);
        exp_data(2, 3'd0, 32'd15, "sat_cycles_15"); step();
        set_pc(32'h4300);
        exp_data(2, 3'd0, 32'd15, "sat_no_wrap");   step();

        sel_i = 3'd0;
        step(); step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ucsbece154b_perf_monitor.md
UCSBECE154B_PERF_MONITOR -- requirements
Module: ucsbece154b_perf_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning the width of every event counter.
REQ-002 SHALL have parameter MAX_CYCLES, default 500, meaning the RUN-cycle limit that forces TIMEOUT.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-005 SHALL have port en_i, input, 1 bit: start monitoring (IDLE->RUN).
REQ-006 SHALL have port clear_i, input, 1 bit: synchronous clear of counters and state to IDLE.
REQ-007 SHALL have ports issue1_i and issue2_i, input, 1 bit each: slot 1 or slot 2 decoded a non-bubble, non-NOP instruction this cycle.
REQ-008 SHALL have ports branchE_i, mispredictE_i, jumpE_i and jumpTakenF_i, input, 1 bit each: slot-1 execute branch, branch mispredicted, jump (JAL/JALR), jump predicted taken.
REQ-009 SHALL have ports pcF1_i, pcF2_i, instrF1_i and instrF2_i, input, 32 bits each: fetch PCs and instructions for slots 1/2.
REQ-010 SHALL have port sel_i, input, 3 bits: readout select.
REQ-011 SHALL have port data_o, output, 32 bits: registered readout, zero-extended or truncated from CNT_W.
REQ-012 SHALL have ports halted_o and timeout_o, output, 1 bit each: the HALTED / TIMEOUT state.

Function
REQ-013 SHALL implement FSM IDLE, RUN, HALTED, TIMEOUT; IDLE->RUN when en_i=1; HALTED and TIMEOUT hold until clear_i or reset.
REQ-014 SHALL count only in RUN: cycles +1 per cycle; instr += issue1_i+issue2_i (0..2); branches on branchE_i; br_miss on branchE_i&mispredictE_i; jumps on jumpE_i; jump_miss on jumpE_i&!jumpTakenF_i.
REQ-015 SHALL saturate every counter at 2^CNT_W-1, with no wrap; an instr increment of 2 from all-ones-minus-1 SHALL yield all-ones.
REQ-016 SHALL register pcF1_i/pcF2_i each RUN cycle into prev registers plus a prev_valid flag, cleared on entry to RUN.
REQ-017 SHALL define halt condition as prev_valid & pcF1_i==prev1 & pcF2_i==prev2 & instrF1_i==32'h00000013 & instrF2_i==32'h00000013.
REQ-018 SHALL go RUN->HALTED on the halt condition, and SHALL NOT count events in the detection cycle.
REQ-019 SHALL go RUN->TIMEOUT when cycles==MAX_CYCLES-1 would increment, counting that final cycle, so cycles==MAX_CYCLES in TIMEOUT.
REQ-020 SHALL give halt priority over timeout when both occur in the same cycle: state HALTED, cycle not counted.
REQ-021 SHALL give clear_i priority over en_i and all events: the next state is IDLE, counters 0, prev_valid 0.
REQ-022 SHALL update data_o one cycle after sel_i: 0 cycles, 1 instr, 2 branches, 3 br_miss, 4 jumps, 5 jump_miss, 6 {30'b0,state[1:0]}, 7 zero.
REQ-023 SHALL encode state as IDLE=0, RUN=1, HALTED=2, TIMEOUT=3.
REQ-024 SHALL drive halted_o and timeout_o directly from state with no added latency.

Reset
REQ-025 SHALL, with reset=0 at a rising edge, set state IDLE, all counters 0, prev regs 0, prev_valid 0, data_o 0, halted_o 0, timeout_o 0.
REQ-026 SHALL let reset asserted mid-RUN discard all counts, and SHALL require en_i again to restart.

Structure
REQ-027 SHALL place the state enum, sel codes, NOP constant 32'h00000013 and the default MAX_CYCLES in shared package ucsbece154b_perf_pkg.
REQ-028 SHALL use one sub-module, ucsbece154b_sat_counter (parameter W, inputs clr, inc[1:0], output q), instantiated six times.

Verification
REQ-029 SHALL cover reset then en_i=1, 10 RUN cycles with issue1_i=issue2_i=1 -> sel 0 gives 10, sel 1 gives 20.
REQ-030 SHALL cover 4 branches with 1 mispredict and 3 jumps with jumpTakenF_i=0 once -> sel2=4, sel3=1, sel4=3, sel5=1.
REQ-031 SHALL cover PCs 0x40/0x44 with NOPs held 2 cycles after 5 RUN cycles -> halted_o=1, cycles=6, sel6=2.
REQ-032 SHALL cover MAX_CYCLES=8 with no halt -> timeout_o=1 after 8 RUN cycles, cycles=8; halt injected on cycle 8 instead -> HALTED, cycles=7.
REQ-033 SHALL cover CNT_W=4, cycles=14 and instr=14, then one cycle with dual issue -> cycles=15, instr=15 saturated.
REQ-034 SHALL cover clear_i and en_i both 1 in HALTED -> IDLE, all counters 0; reset=0 mid-RUN -> all outputs 0.
